dram_write_responder: RTL
=========================

Name: dram_write_responder

Overview:
- Synthesizable AXI3 write-channel responder (slave) that terminates the 64-bit HP-port write bursts issued by DramWriterBuf.
- Stores the accepted data in an internal word-addressed RAM and returns a B response per burst.
- Offers a 1-cycle read-back port and status counters for loopback and bring-up builds where the PS7 HP port is not used.
- Single outstanding burst; no IDs, matching the HP2 write channel wiring.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address mapped to RAM word 0 (8-byte aligned)
- MEM_AW, 10, log2 of RAM depth in 64-bit words (window = 8*2^MEM_AW bytes)

Ports:
- fclk  input  1  sole clock
- rst  input  1  reset, asynchronous, active-high
- S_AXI_AWADDR  input  32  burst start byte address
- S_AXI_AWLEN  input  4  beats-1 (AXI3, 1..16 beats)
- S_AXI_AWSIZE  input  3  beat size code; only 3'b011 (8 bytes) is legal
- S_AXI_AWBURST  input  2  burst type; only 2'b01 (INCR) is legal
- S_AXI_AWVALID  input  1  AW valid
- S_AXI_AWREADY  output  1  AW ready
- S_AXI_WDATA  input  64  write data
- S_AXI_WSTRB  input  8  byte enables
- S_AXI_WVALID  input  1  W valid
- S_AXI_WLAST  input  1  last beat marker
- S_AXI_WREADY  output  1  W ready
- S_AXI_BRESP  output  2  2'b00 OKAY, 2'b10 SLVERR
- S_AXI_BVALID  output  1  B valid
- S_AXI_BREADY  input  1  B ready
- rd_addr  input  MEM_AW  RAM word index for read-back
- rd_data  output  64  RAM word, registered
- beats_written  output  32  count of W handshakes that committed to RAM
- bursts_done  output  32  count of completed B handshakes
- err_flags  output  3  sticky: [0] bad size/burst, [1] out of window, [2] WLAST mismatch

Behaviour:
- Reset: AWREADY=1, WREADY=0, BVALID=0, BRESP=0, rd_data=0, counters=0, err_flags=0, FSM=IDLE. RAM contents are not cleared. Reset asserted mid-burst aborts the burst: no B is issued and partial RAM writes remain.
- IDLE (AWREADY=1):
  - On AWVALID&AWREADY, latch addr, len, and bad = (AWSIZE!=3 || AWBURST!=1).
  - Set beat counter = 0, go to DATA.
- DATA (WREADY=1, AWREADY=0):
  - Each WVALID&WREADY handshake with cur_addr = addr + 8*beat:
    - oow = cur_addr < BASE_ADDR || cur_addr >= BASE_ADDR + 8*2^MEM_AW.
    - If !bad and !oow: write RAM[(cur_addr-BASE_ADDR)>>3] byte-wise under WSTRB and increment beats_written.
    - If bad or oow: suppress the write, set the burst error bit, and set err_flags[0]/[1] respectively.
  - WLAST is checked but not obeyed. Any beat where WLAST != (beat==len) sets err_flags[2]; this does not affect BRESP.
  - The burst ends on beat == len; go to RESP.
- RESP (BVALID=1, WREADY=0):
  - BRESP = 2'b10 if any beat of the burst errored, else 2'b00.
  - BRESP is stable while BVALID is high.
  - On BREADY: increment bursts_done, go to IDLE.
- Latency:
  - AW handshake at cycle N gives WREADY=1 at N+1.
  - Last W handshake at cycle M gives BVALID=1 at M+1.
  - B handshake at cycle K gives AWREADY=1 at K+1.
  - AW or W offered in the wrong state is left stalled (ready low), never dropped.
- Address arithmetic is 32-bit. A burst running past the window end makes only the overflowing beats errored; there is no wrap into the RAM.
- Read-back: rd_data <= RAM[rd_addr] each cycle (1-cycle latency).
  - On a same-cycle write to the same word, rd_data returns the old contents (read-first).
- Counters wrap modulo 2^32. err_flags are cleared only by rst.

Decomposition:
- Shared package: AXI_BURST_INCR=2'b01, AXI_SIZE_8B=3'b011, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, and the FSM state enum {IDLE, DATA, RESP}.
- One sub-module, wr_ram_be: single-clock 2^MEM_AW x 64 RAM with a byte-enable write port and a registered read-first read port, inferred as BRAM.

Test Plan:
- AW addr=BASE+0x10, len=3, size=3, INCR; 4 beats with data 0x11..0x44, WSTRB=FF, WLAST on beat 3 -> BVALID one cycle after beat 3, BRESP=00; rd_addr 2..5 return 0x11..0x44; beats_written=4; bursts_done=1 after BREADY.
- Write 0xFFFF_FFFF_FFFF_FFFF to word 0, then a 1-beat write of 0 with WSTRB=8'h0F -> rd_data[0]=0xFFFF_FFFF_0000_0000.
- AWSIZE=3'b010, len=1 -> both beats accepted, RAM unchanged, BRESP=10, err_flags=3'b001.
- MEM_AW=4, addr=BASE+0x78, len=1 -> beat 0 writes word 15, beat 1 is suppressed, BRESP=10, err_flags[1]=1, beats_written=1.
- len=3 with WLAST on beat 1 and WVALID held -> 4 beats still consumed, BVALID after beat 3, err_flags[2]=1, BRESP=00.
- Hold BREADY=0 for 5 cycles, then raise rst mid-DATA on the following burst -> BVALID/BRESP stable during the stall; after rst, AWREADY=1, BVALID=0, counters=0, and previously written RAM data is intact.

Source files
------------

// File: rtl/dram_write_responder_pkg.sv
// Shared definitions for the DRAM write responder.
// Holds the legal AXI3 size/burst codes, the B-channel response codes and
// the FSM state type used by the top level.
package dram_write_responder_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dram_write_responder_wr_ram_be.sv
// wr_ram_be: single-clock 2^MEM_AW x 64-bit RAM.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (clears only the read register)
//   wr_en    - write enable
//   wr_addr  - write word index
//   wr_data  - write data
//   wr_strb  - per-byte write enables
//   rd_addr  - read word index
//   rd_data  - registered read data, read-first on address collision
module wr_ram_be #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic [7:0]        wr_strb,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [63:0]       rd_data
);

    logic [63:0] mem [2**MEM_AW];

    // Contents are deliberately not reset so data survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read of the array gives old data on a same-word write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 64'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dram_write_responder.sv
// dram_write_responder: AXI3 write-channel slave terminating 64-bit bursts
// into an internal RAM, with one outstanding burst and no IDs.
// Ports:
//   fclk, rst             - clock, asynchronous active-high reset
//   S_AXI_AW*             - write address channel
//   S_AXI_W*              - write data channel
//   S_AXI_B*              - write response channel
//   rd_addr / rd_data     - 1-cycle registered read-back port
//   beats_written         - W beats that were committed to RAM
//   bursts_done           - completed B handshakes
//   err_flags             - sticky [0] bad size/burst, [1] out of window,
//                           [2] WLAST mismatch
module dram_write_responder
    import dram_write_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_AW    = 10
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic [3:0]        S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [63:0]       S_AXI_WDATA,
    input  logic [7:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    input  logic              S_AXI_WLAST,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [63:0]       rd_data,
    output logic [31:0]       beats_written,
    output logic [31:0]       bursts_done,
    output logic [2:0]        err_flags
);

    // One past the last byte of the window; 33 bits so a window ending at
    // 4 GiB does not wrap to zero.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd8 << MEM_AW);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [3:0]  len_reg;
    logic [3:0]  beat_reg;
    logic        bad_reg;
    logic        burst_err_reg;
    logic        awready_reg;
    logic        wready_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic [31:0] beats_written_reg;
    logic [31:0] bursts_done_reg;
    logic [2:0]  err_flags_reg;

    logic [31:0]       cur_addr;
    logic              oow;
    logic              w_hs;
    logic              wr_en;
    logic              last_beat;
    logic [MEM_AW-1:0] wr_word;

    assign cur_addr  = addr_reg + {25'd0, beat_reg, 3'b000};
    assign oow       = (cur_addr < BASE_ADDR) || ({1'b0, cur_addr} >= WIN_END);
    assign wr_word   = MEM_AW'((cur_addr - BASE_ADDR) >> 3);
    assign w_hs      = (state_reg == DATA) && wready_reg && S_AXI_WVALID;
    assign wr_en     = w_hs && !bad_reg && !oow;
    assign last_beat = (beat_reg == len_reg);

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            addr_reg          <= 32'd0;
            len_reg           <= 4'd0;
            beat_reg          <= 4'd0;
            bad_reg           <= 1'b0;
            burst_err_reg     <= 1'b0;
            awready_reg       <= 1'b1;
            wready_reg        <= 1'b0;
            bvalid_reg        <= 1'b0;
            bresp_reg         <= AXI_RESP_OKAY;
            beats_written_reg <= 32'd0;
            bursts_done_reg   <= 32'd0;
            err_flags_reg     <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (S_AXI_AWVALID && awready_reg) begin
                        addr_reg      <= S_AXI_AWADDR;
                        len_reg       <= S_AXI_AWLEN;
                        bad_reg       <= (S_AXI_AWSIZE != AXI_SIZE_8B) ||
                                         (S_AXI_AWBURST != AXI_BURST_INCR);
                        beat_reg      <= 4'd0;
                        burst_err_reg <= 1'b0;
                        awready_reg   <= 1'b0;
                        wready_reg    <= 1'b1;
                        state_reg     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (wr_en) begin
                            beats_written_reg <= beats_written_reg + 32'd1;
                        end
                        if (bad_reg || oow) begin
                            burst_err_reg <= 1'b1;
                        end
                        if (bad_reg) begin
                            err_flags_reg[0] <= 1'b1;
                        end
                        if (oow) begin
                            err_flags_reg[1] <= 1'b1;
                        end
                        // WLAST is only audited; the beat count from AWLEN
                        // decides where the burst ends.
                        if (S_AXI_WLAST != last_beat) begin
                            err_flags_reg[2] <= 1'b1;
                        end
                        if (last_beat) begin
                            wready_reg <= 1'b0;
                            bvalid_reg <= 1'b1;
                            // Include the current beat's error, not yet in
                            // burst_err_reg.
                            bresp_reg  <= (burst_err_reg || bad_reg || oow) ?
                                          AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            state_reg  <= RESP;
                        end else begin
                            beat_reg <= beat_reg + 4'd1;
                        end
                    end
                end
                RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_reg      <= 1'b0;
                        awready_reg     <= 1'b1;
                        bursts_done_reg <= bursts_done_reg + 32'd1;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    awready_reg <= 1'b1;
                    wready_reg  <= 1'b0;
                    bvalid_reg  <= 1'b0;
                end
            endcase
        end
    end

    wr_ram_be #(
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk     (fclk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_word),
        .wr_data (S_AXI_WDATA),
        .wr_strb (S_AXI_WSTRB),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign beats_written = beats_written_reg;
    assign bursts_done   = bursts_done_reg;
    assign err_flags     = err_flags_reg;

endmodule
